// File: rtl/seven_seg_mux.sv
// Time-multiplexed hex display driver: per-slot blanking deadtime, frame-synchronous shadow update.
// Optional leading-zero blanking is enabled by defining SEVEN_SEG_MUX_LZB_EN.
module seven_seg_mux #(
   parameter int   NUM_DIGITS     = 4,
   parameter int   SLOT_CYCLES    = 24000,
   parameter int   DEADTIME       = 16,
   parameter logic SEG_ACTIVE_LOW = 1'b1,
   parameter logic AN_ACTIVE_LOW  = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value,
   output logic [6:0]              seg,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_done
);

   localparam int CNT_W = $clog2(SLOT_CYCLES);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SLOT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEADTIME);
   localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(NUM_DIGITS - 1);
   localparam logic [6:0]            SEG_POL = {7{SEG_ACTIVE_LOW}};
   localparam logic [NUM_DIGITS-1:0] AN_POL  = {NUM_DIGITS{AN_ACTIVE_LOW}};

   typedef enum logic {BLANK, ON} state_t;

   state_t                  state;
   logic [CNT_W-1:0]        slot_cnt;
   logic [CNT_W-1:0]        cnt_next;
   logic [IDX_W-1:0]        digit_idx;
   logic [4*NUM_DIGITS-1:0] pending;
   logic [4*NUM_DIGITS-1:0] shadow;
   logic                    slot_wrap;
   logic                    frame_wrap;
   logic [3:0]              cur_nib;
   logic [NUM_DIGITS-1:0]   onehot;
   logic                    digit_blank;

   // Active-high glyphs, bit order {g,f,e,d,c,b,a}
   function automatic logic [6:0] glyph(input logic [3:0] nib);
      case (nib)
         4'h0: glyph = 7'h3F;
         4'h1: glyph = 7'h06;
         4'h2: glyph = 7'h5B;
         4'h3: glyph = 7'h4F;
         4'h4: glyph = 7'h66;
         4'h5: glyph = 7'h6D;
         4'h6: glyph = 7'h7D;
         4'h7: glyph = 7'h07;
         4'h8: glyph = 7'h7F;
         4'h9: glyph = 7'h6F;
         4'hA: glyph = 7'h77;
         4'hB: glyph = 7'h7C;
         4'hC: glyph = 7'h39;
         4'hD: glyph = 7'h5E;
         4'hE: glyph = 7'h79;
         default: glyph = 7'h71;
      endcase
   endfunction

   always_comb begin
      slot_wrap  = (slot_cnt == CNT_MAX);
      frame_wrap = slot_wrap && (digit_idx == IDX_MAX);
      cnt_next   = slot_wrap ? '0 : slot_cnt + 1'b1;
   end

`ifdef SEVEN_SEG_MUX_LZB_EN
   logic [NUM_DIGITS-1:0] lead_zero;
   logic                  zero_run;

   // lead_zero[k]: nibble k and every nibble above it are zero
   always_comb begin
      lead_zero = '0;
      zero_run  = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         zero_run     = zero_run && (shadow[4*k +: 4] == 4'h0);
         lead_zero[k] = zero_run;
      end
   end
`endif

   always_comb begin
      cur_nib     = 4'h0;
      onehot      = '0;
      digit_blank = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (digit_idx == IDX_W'(k)) begin
            cur_nib   = shadow[4*k +: 4];
            onehot[k] = 1'b1;
`ifdef SEVEN_SEG_MUX_LZB_EN
            digit_blank = (k != 0) && lead_zero[k];
`endif
         end
      end
   end

   // State tracks the current counter; outputs register one cycle behind it
   always_ff @(posedge clk) begin
      if (reset) begin
         slot_cnt   <= '0;
         digit_idx  <= '0;
         pending    <= '0;
         shadow     <= '0;
         state      <= BLANK;
         seg        <= SEG_POL;
         an         <= AN_POL;
         frame_done <= 1'b0;
      end else begin
         if (load)
            pending <= value;
         slot_cnt <= cnt_next;
         state    <= (cnt_next < CNT_DEAD) ? BLANK : ON;
         if (slot_wrap)
            digit_idx <= frame_wrap ? '0 : digit_idx + 1'b1;
         if (frame_wrap)
            shadow <= pending;
         frame_done <= frame_wrap;
         if (state == ON) begin
            an  <= onehot ^ AN_POL;
            seg <= (digit_blank ? 7'h00 : glyph(cur_nib)) ^ SEG_POL;
         end else begin
            an  <= AN_POL;
            seg <= SEG_POL;
         end
      end
   end

endmodule

// File: tb/tb_seven_seg_mux.sv
// Directed scoreboard bench for seven_seg_mux (4 digits, 8-cycle slots, 2-cycle deadtime, active-low).
module tb_seven_seg_mux;

   localparam int ND   = 4;
   localparam int SLOT = 8;
   localparam int DT   = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        load;
   logic [15:0] value;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        frame_done;

   typedef struct {
      logic [6:0] seg;
      logic [3:0] an;
      logic       fd;
      string      tag;
   } exp_t;

   exp_t sb[$];
   int   compared   = 0;
   int   mismatched = 0;

   seven_seg_mux #(
      .NUM_DIGITS(ND), .SLOT_CYCLES(SLOT), .DEADTIME(DT),
      .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk), .reset(reset), .load(load), .value(value),
      .seg(seg), .an(an), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] glyph_hi(input logic [3:0] n);
      case (n)
         4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
         4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
         4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
         4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
      endcase
   endfunction

   // Expected active-low segment pattern for digit d of a displayed value
   function automatic logic [6:0] exp_seg(input logic [15:0] v, input int d);
      logic [3:0] n;
      n = v[4*d +: 4];
`ifdef SEVEN_SEG_MUX_LZB_EN
      if (d > 0 && (v >> (4*d)) == 16'h0) return 7'h7F;
`endif
      return ~glyph_hi(n);
   endfunction

   task automatic push(input logic [6:0] s, input logic [3:0] a, input logic f, input string t);
      exp_t e;
      e.seg = s; e.an = a; e.fd = f; e.tag = t;
      sb.push_back(e);
   endtask

   task automatic tick_check();
      exp_t e;
      @(posedge clk);
      #1;
      compared++;
      assert (sb.size() > 0) else begin
         mismatched++;
         $error("FAIL scoreboard_empty: got 0 entries, required >0");
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         compared++;
         assert (seg === e.seg) else begin
            mismatched++;
            $error("FAIL %s seg: got %h, required %h", e.tag, seg, e.seg);
         end
         compared++;
         assert (an === e.an) else begin
            mismatched++;
            $error("FAIL %s an: got %h, required %h", e.tag, an, e.an);
         end
         compared++;
         assert (frame_done === e.fd) else begin
            mismatched++;
            $error("FAIL %s frame_done: got %b, required %b", e.tag, frame_done, e.fd);
         end
      end
   endtask

   // One output-aligned slot: DT blank cycles, then digit d lit; optional one-cycle load at cycle load_at
   task automatic run_slot(input int d, input logic [15:0] shown, input bit fd_end,
                           input int load_at, input logic [15:0] lv, input int ncyc,
                           input string tag);
      for (int i = 0; i < ncyc; i++) begin
         if (i == load_at) begin
            load  = 1'b1;
            value = lv;
         end
         if (i < DT)
            push(7'h7F, 4'hF, 1'b0, $sformatf("%s_d%0d_c%0d", tag, d, i));
         else
            push(exp_seg(shown, d), 4'(~(4'b0001 << d)), fd_end && (i == SLOT - 1),
                 $sformatf("%s_d%0d_c%0d", tag, d, i));
         tick_check();
         load = 1'b0;
      end
   endtask

   task automatic run_frame(input logic [15:0] shown, input int load_slot, input int load_at,
                            input logic [15:0] lv, input string tag);
      for (int d = 0; d < ND; d++)
         run_slot(d, shown, d == ND - 1, (d == load_slot) ? load_at : -1, lv, SLOT, tag);
   endtask

   initial begin
      reset = 1'b1;
      load  = 1'b0;
      value = 16'h0;

      for (int i = 0; i < 3; i++) begin
         push(7'h7F, 4'hF, 1'b0, $sformatf("reset_c%0d", i));
         tick_check();
      end
      reset = 1'b0;

      // Shadow starts at zero; load 12AF during digit 0
      run_frame(16'h0000, 0, 3, 16'h12AF, "f0");
      // 12AF frame; reload 0000 mid-frame must not tear
      run_frame(16'h12AF, 1, 3, 16'h0000, "f1");
      // Load 0050 exactly on the wrap edge: next frame still shows old pending
      run_frame(16'h0000, 3, 7, 16'h0050, "f2");
      run_frame(16'h0000, -1, -1, 16'h0, "f3");
      // 0050 frame, interrupted by reset during digit 2 ON
      run_slot(0, 16'h0050, 1'b0, -1, 16'h0, SLOT, "f4");
      run_slot(1, 16'h0050, 1'b0, -1, 16'h0, SLOT, "f4");
      run_slot(2, 16'h0050, 1'b0, -1, 16'h0, 4, "f4");
      reset = 1'b1;
      push(7'h7F, 4'hF, 1'b0, "midreset");
      tick_check();
      reset = 1'b0;
      // Both shadow and pending were cleared
      run_frame(16'h0000, -1, -1, 16'h0, "f5");
      run_frame(16'h0000, -1, -1, 16'h0, "f6");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
